// File: rtl/sdes_rx_pkg.sv
// Shared types and defaults for the serial-to-parallel receiver.
package sdes_rx_pkg;

   // Word-alignment state: searching for the sync word, or locked to it.
   typedef enum logic {
      HUNT = 1'b0,
      LOCK = 1'b1
   } state_t;

   // Defaults; the sync word is held 32 bits wide so narrower words can slice it.
   localparam int          DEF_N         = 8;
   localparam logic [31:0] DEF_SYNC_WORD = 32'h0000_00A5;
   localparam int          DEF_CNT_W     = 16;

endpackage

// File: rtl/sdes_out_buf.sv
// One-entry valid/ready holding register for assembled words.
// Tracks dropped words (sticky overflow) and counts accepted words (saturating).
module sdes_out_buf
   import sdes_rx_pkg::*;
#(
   parameter int W     = DEF_N,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             word_valid,
   input  logic [W-1:0]     word,
   output logic [W-1:0]     data_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             overflow,
   output logic [CNT_W-1:0] word_cnt
);

   logic buf_free;
   logic cnt_full;

   // The slot can take a new word if empty or being drained this same cycle.
   assign buf_free = !out_valid || out_ready;
   assign cnt_full = &word_cnt;

   // Holding register, handshake, overflow flag and accepted-word counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_out  <= '0;
         out_valid <= 1'b0;
         overflow  <= 1'b0;
         word_cnt  <= '0;
      end else begin
         if (word_valid && buf_free) begin
            data_out  <= word;
            out_valid <= 1'b1;
            if (!cnt_full) begin
               word_cnt <= word_cnt + 1'b1;
            end
         end else if (word_valid) begin
            // Slot still owned by downstream: drop the new word, keep the old one.
            overflow <= 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/sdes_rx.sv
// Serial-to-parallel receiver: hunts an LSB-first bit stream for a sync word,
// locks word alignment to it, then assembles N-bit words into a holding register.
module sdes_rx
   import sdes_rx_pkg::*;
#(
   parameter int           N         = DEF_N,
   parameter logic [N-1:0] SYNC_WORD = DEF_SYNC_WORD[N-1:0],
   parameter int           CNT_W     = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sin,
   input  logic             en,
   input  logic             resync,
   output logic [N-1:0]     data_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             locked,
   output logic             overflow,
   output logic [CNT_W-1:0] word_cnt
);

   localparam int BW = $clog2(N);
   localparam int FW = $clog2(N + 1);

   state_t        state;
   state_t        state_next;
   logic [N-1:0]  sh;
   logic [N-1:0]  sh_next;
   logic [BW-1:0] bit_cnt;
   logic [FW-1:0] fill_cnt;
   logic          fill_ok;
   logic          last_bit;
   logic          word_valid;

   // New bits enter at the top so the first-received bit ends up in bit 0.
   assign sh_next  = {sin, sh[N-1:1]};
   // At least N bits (including the current one) seen since reset/resync,
   // so the zeroed shift register can never produce a false sync match.
   assign fill_ok  = (fill_cnt >= FW'(N - 1));
   assign last_bit = (bit_cnt == BW'(N - 1));

   // Shift register and fill counter; resync wipes any partial history.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh       <= '0;
         fill_cnt <= '0;
      end else if (resync) begin
         sh       <= '0;
         fill_cnt <= '0;
      end else if (en) begin
         sh <= sh_next;
         if (fill_cnt != FW'(N)) begin
            fill_cnt <= fill_cnt + 1'b1;
         end
      end
   end

   // Bit position within the current word; only advances while locked.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt <= '0;
      end else if (resync || state == HUNT) begin
         bit_cnt <= '0;
      end else if (en) begin
         bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= HUNT;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: lock on an aligned sync word, stay locked until resync.
   always_comb begin
      state_next = state;
      if (resync) begin
         state_next = HUNT;
      end else begin
         case (state)
            HUNT: begin
               if (en && fill_ok && (sh_next == SYNC_WORD)) begin
                  state_next = LOCK;
               end
            end
            LOCK: begin
               state_next = LOCK;
            end
            default: begin
               state_next = HUNT;
            end
         endcase
      end
   end

   // Output logic: lock indicator and word-complete strobe to the holding register.
   always_comb begin
      locked     = (state == LOCK);
      word_valid = (state == LOCK) && en && !resync && last_bit;
   end

   sdes_out_buf #(
      .W     (N),
      .CNT_W (CNT_W)
   ) u_out_buf (
      .clk        (clk),
      .rst        (rst),
      .word_valid (word_valid),
      .word       (sh_next),
      .data_out   (data_out),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .overflow   (overflow),
      .word_cnt   (word_cnt)
   );

endmodule

// File: tb/tb_sdes_rx.sv
// Directed bench for sdes_rx: sync hunt, word assembly, handshake, overflow,
// en gaps, resync and asynchronous reset.
module tb_sdes_rx;

   localparam int N     = 8;
   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             sin = 1'b0;
   logic             en = 1'b0;
   logic             resync = 1'b0;
   logic             out_ready = 1'b0;

   logic [N-1:0]     data_out;
   logic             out_valid;
   logic             locked;
   logic             overflow;
   logic [CNT_W-1:0] word_cnt;

   logic [N-1:0]     z_data_out;
   logic             z_out_valid;
   logic             z_locked;
   logic             z_overflow;
   logic [CNT_W-1:0] z_word_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sdes_rx #(.N(N), .SYNC_WORD(8'hA5), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .sin       (sin),
      .en        (en),
      .resync    (resync),
      .data_out  (data_out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .locked    (locked),
      .overflow  (overflow),
      .word_cnt  (word_cnt)
   );

   // Second instance with an all-zero sync word to exercise the fill guard.
   sdes_rx #(.N(N), .SYNC_WORD(8'h00), .CNT_W(CNT_W)) dut_z (
      .clk       (clk),
      .rst       (rst),
      .sin       (sin),
      .en        (en),
      .resync    (resync),
      .data_out  (z_data_out),
      .out_valid (z_out_valid),
      .out_ready (1'b1),
      .locked    (z_locked),
      .overflow  (z_overflow),
      .word_cnt  (z_word_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, obs, exp, $time);
      end else begin
         $display("ok   %s = %0h @%0t", tag, obs, $time);
      end
   endtask

   // One qualified bit; returns 1 time unit after the sampling edge.
   task automatic send_bit(input logic b);
      sin = b;
      en  = 1'b1;
      @(posedge clk);
      #1;
      en  = 1'b0;
      sin = 1'b0;
   endtask

   task automatic send_bits(input logic [N-1:0] w, input int first, input int count);
      for (int i = first; i < first + count; i++) begin
         send_bit(w[i]);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #2;
      rst = 1'b0;
      idle(1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [N-1:0] w;

      // Reset state
      #3;
      check("rst_data", 32'(data_out), 32'h0);
      check("rst_valid", 32'(out_valid), 32'h0);
      check("rst_locked", 32'(locked), 32'h0);
      check("rst_ovf", 32'(overflow), 32'h0);
      check("rst_cnt", 32'(word_cnt), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      idle(1);

      // 1: sync A5 then word 3C
      out_ready = 1'b1;
      w = 8'hA5;
      send_bits(w, 0, 7);
      check("t1_nolock7", 32'(locked), 32'h0);
      send_bit(w[7]);
      check("t1_lock", 32'(locked), 32'h1);
      check("t1_sync_not_emitted", 32'(out_valid), 32'h0);
      w = 8'h3C;
      send_bits(w, 0, 7);
      check("t1_valid7", 32'(out_valid), 32'h0);
      send_bit(w[7]);
      check("t1_valid", 32'(out_valid), 32'h1);
      check("t1_data", 32'(data_out), 32'h3C);
      check("t1_cnt", 32'(word_cnt), 32'h1);
      idle(1);
      check("t1_drain_valid", 32'(out_valid), 32'h0);
      check("t1_drain_data", 32'(data_out), 32'h3C);

      // 2a: all-zero sync word must not match the zeroed shift register early
      do_reset();
      check("t2_cnt_after_rst", 32'(word_cnt), 32'h0);
      w = 8'h00;
      send_bits(w, 0, 7);
      check("t2z_nolock7", 32'(z_locked), 32'h0);
      send_bit(w[7]);
      check("t2z_lock8", 32'(z_locked), 32'h1);
      check("t2_a5_nolock_zeros", 32'(locked), 32'h0);

      // 2b: garbage bit then A5; lock only on the aligned pattern
      do_reset();
      send_bit(1'b1);
      w = 8'hA5;
      send_bits(w, 0, 7);
      check("t2_nolock_misaligned", 32'(locked), 32'h0);
      send_bit(w[7]);
      check("t2_lock", 32'(locked), 32'h1);

      // 3: back-pressure and overflow
      out_ready = 1'b0;
      w = 8'h11;
      send_bits(w, 0, 8);
      check("t3_w11_valid", 32'(out_valid), 32'h1);
      check("t3_w11_data", 32'(data_out), 32'h11);
      check("t3_w11_ovf", 32'(overflow), 32'h0);
      w = 8'h22;
      send_bits(w, 0, 8);
      check("t3_w22_ovf", 32'(overflow), 32'h1);
      check("t3_w22_data_held", 32'(data_out), 32'h11);
      check("t3_w22_cnt", 32'(word_cnt), 32'h1);
      w = 8'h33;
      send_bits(w, 0, 7);
      out_ready = 1'b1;
      send_bit(w[7]);
      out_ready = 1'b0;
      check("t3_w33_data", 32'(data_out), 32'h33);
      check("t3_w33_valid", 32'(out_valid), 32'h1);
      check("t3_w33_cnt", 32'(word_cnt), 32'h2);

      // 4: en gaps during word 5A
      out_ready = 1'b1;
      idle(1);
      out_ready = 1'b0;
      check("t4_drained", 32'(out_valid), 32'h0);
      w = 8'h5A;
      for (int i = 0; i < 7; i++) begin
         idle(1);
         send_bit(w[i]);
      end
      idle(1);
      check("t4_valid_gap", 32'(out_valid), 32'h0);
      check("t4_still_locked", 32'(locked), 32'h1);
      send_bit(w[7]);
      check("t4_valid", 32'(out_valid), 32'h1);
      check("t4_data", 32'(data_out), 32'h5A);
      check("t4_cnt", 32'(word_cnt), 32'h3);

      // 5: resync mid-word, then re-align
      out_ready = 1'b1;
      idle(1);
      out_ready = 1'b0;
      w = 8'h99;
      send_bits(w, 0, 3);
      resync = 1'b1;
      idle(1);
      resync = 1'b0;
      check("t5_unlocked", 32'(locked), 32'h0);
      send_bits(w, 3, 5);
      check("t5_no_emit", 32'(out_valid), 32'h0);
      check("t5_still_hunt", 32'(locked), 32'h0);
      w = 8'hA5;
      send_bits(w, 0, 8);
      check("t5_relock", 32'(locked), 32'h1);
      w = 8'h7E;
      send_bits(w, 0, 8);
      check("t5_data", 32'(data_out), 32'h7E);
      check("t5_valid", 32'(out_valid), 32'h1);
      check("t5_ovf_kept", 32'(overflow), 32'h1);
      check("t5_cnt", 32'(word_cnt), 32'h4);

      // 6: asynchronous reset between edges
      w = 8'hC3;
      send_bits(w, 0, 3);
      #2;
      rst = 1'b1;
      #1;
      check("t6_data", 32'(data_out), 32'h0);
      check("t6_valid", 32'(out_valid), 32'h0);
      check("t6_locked", 32'(locked), 32'h0);
      check("t6_ovf", 32'(overflow), 32'h0);
      check("t6_cnt", 32'(word_cnt), 32'h0);
      idle(1);
      rst = 1'b0;
      idle(1);
      check("t6_post_locked", 32'(locked), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
